// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: controller request/response handshake plus RTC strobe pins.
interface rtc_bus_ctrl_if;
  logic       start_i;
  logic       rw_i;
  logic [7:0] addr_i;
  logic [7:0] wdata_i;
  logic [7:0] rdata_o;
  logic       busy_o;
  logic       done_o;
  logic       ad_o;
  logic       cs_o;
  logic       rd_o;
  logic       wr_o;
  modport master (
    output start_i, rw_i, addr_i, wdata_i,
    input  rdata_o, busy_o, done_o, ad_o, cs_o, rd_o, wr_o
  );
  modport slave (
    input  start_i, rw_i, addr_i, wdata_i,
    output rdata_o, busy_o, done_o, ad_o, cs_o, rd_o, wr_o
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: multiplexed address/data bus-cycle engine for the RTC pins.
// Optional RTC_BUS_ADDR_SKIP_EN skips the address phase when the address repeats.
module rtc_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 10,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 5
) (
  input  logic         clk,
  input  logic         reset,
  rtc_bus_ctrl_if.slave bus,
  inout  wire  [7:0]   bus_io
);
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD} state_t;
  localparam logic [7:0] C_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] C_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] C_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] C_GAP   = 8'(T_GAP - 1);
  state_t     state;
  logic [7:0] cnt;
  logic [7:0] wdata_q;
  logic [7:0] dout;
  logic       rw_q;
  logic       oe;
  logic       last;
  logic       skip;
  assign bus_io = oe ? dout : 8'hzz;
  assign last = cnt == 8'd0;
`ifdef RTC_BUS_ADDR_SKIP_EN
  logic       valid;
  logic [7:0] last_addr;
  assign skip = valid && bus.addr_i == last_addr;
  // only a completed transaction validates the stored address; reset aborts clear it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid     <= 1'b0;
      last_addr <= 8'h00;
    end else begin
      if (state == IDLE && bus.start_i) last_addr <= bus.addr_i;
      if (state == D_HOLD && last) valid <= 1'b1;
    end
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 8'h00;
      rw_q        <= 1'b0;
      wdata_q     <= 8'h00;
      dout        <= 8'h00;
      oe          <= 1'b0;
      bus.ad_o    <= 1'b1;
      bus.cs_o    <= 1'b1;
      bus.rd_o    <= 1'b1;
      bus.wr_o    <= 1'b1;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
      bus.rdata_o <= 8'h00;
    end else begin
      bus.done_o <= 1'b0;
      if (state != IDLE) cnt <= cnt - 8'd1;
      case (state)
        IDLE: if (bus.start_i) begin
          rw_q       <= bus.rw_i;
          wdata_q    <= bus.wdata_i;
          bus.busy_o <= 1'b1;
          bus.cs_o   <= 1'b0;
          cnt        <= C_SETUP;
          if (skip) begin
            state <= D_SETUP;
            oe    <= !bus.rw_i;
            dout  <= bus.wdata_i;
          end else begin
            state    <= A_SETUP;
            bus.ad_o <= 1'b0;
            oe       <= 1'b1;
            dout     <= bus.addr_i;
          end
        end
        A_SETUP: if (last) begin
          state    <= A_STROBE;
          cnt      <= C_PULSE;
          bus.wr_o <= 1'b0;
        end
        A_STROBE: if (last) begin
          state    <= A_HOLD;
          cnt      <= C_HOLD;
          bus.wr_o <= 1'b1;
        end
        A_HOLD: if (last) begin
          state    <= GAP;
          cnt      <= C_GAP;
          bus.cs_o <= 1'b1;
          bus.ad_o <= 1'b1;
          oe       <= 1'b0;
        end
        GAP: if (last) begin
          state    <= D_SETUP;
          cnt      <= C_SETUP;
          bus.cs_o <= 1'b0;
          oe       <= !rw_q;
          dout     <= wdata_q;
        end
        D_SETUP: if (last) begin
          state    <= D_STROBE;
          cnt      <= C_PULSE;
          bus.wr_o <= rw_q;
          bus.rd_o <= !rw_q;
        end
        D_STROBE: if (last) begin
          state    <= D_HOLD;
          cnt      <= C_HOLD;
          bus.wr_o <= 1'b1;
          bus.rd_o <= 1'b1;
          if (rw_q) bus.rdata_o <= bus_io;
        end
        D_HOLD: if (last) begin
          state      <= IDLE;
          bus.cs_o   <= 1'b1;
          oe         <= 1'b0;
          bus.busy_o <= 1'b0;
          bus.done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: randomized bench comparing pins cycle by cycle against a phase-table model.
module tb_rtc_bus_ctrl;
  localparam int S = 2, P = 10, H = 2, G = 5;
  localparam int A = S + P + H;
`ifdef RTC_BUS_ADDR_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] tb_val = 8'h00;
  wire  [7:0] bus_io;
  int total = 0;
  int bad = 0;
  bit m_valid = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  rtc_bus_ctrl_if ifc ();
  rtc_bus_ctrl #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_GAP(G)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave), .bus_io(bus_io)
  );
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus_io[g]);
  end
  assign bus_io = ifc.rd_o ? 8'hzz : tb_val;
  always #5 clk = ~clk;
  // expected {ad,cs,rd,wr} and bus source (0 Z, 1 addr, 2 wdata, 3 chip) at offset t after accept
  function automatic void model(input int t0, input bit rw, input bit sk, output logic [3:0] pins, output int kind);
    int t;
    t = sk ? t0 + A + G : t0;
    if (t < S) begin pins = 4'b0011; kind = 1; end
    else if (t < S + P) begin pins = 4'b0010; kind = 1; end
    else if (t < A) begin pins = 4'b0011; kind = 1; end
    else if (t < A + G) begin pins = 4'b1111; kind = 0; end
    else if (t < A + G + S) begin pins = 4'b1011; kind = rw ? 0 : 2; end
    else if (t < A + G + S + P) begin pins = rw ? 4'b1001 : 4'b1010; kind = rw ? 3 : 2; end
    else begin pins = 4'b1011; kind = rw ? 0 : 2; end
  endfunction
  task automatic run_txn(input bit rw, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rv,
                         input bit hold_start, input bit poke);
    bit sk;
    int len, kind;
    logic [3:0] pins, got;
    logic [7:0] eb;
    sk = SKIP && m_valid && a == m_addr;
    len = sk ? A : 2 * A + G;
    ifc.rw_i = rw; ifc.addr_i = a; ifc.wdata_i = d; ifc.start_i = 1'b1; tb_val = rv;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) ifc.start_i = 1'b0;
    ifc.rw_i = 1'($urandom); ifc.addr_i = 8'($urandom); ifc.wdata_i = 8'($urandom);
    total++;
    if (ifc.rdata_o !== m_rdata) begin bad++; $display("FAIL rdata_hold got %h want %h", ifc.rdata_o, m_rdata); end
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk);
      if (poke) ifc.start_i = (t == 9);
      model(t, rw, sk, pins, kind);
      got = {ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o};
      total++;
      if (got !== pins) begin bad++; $display("FAIL pins t=%0d got %b want %b", t, got, pins); end
      total++;
      if ({ifc.busy_o, ifc.done_o} !== 2'b10) begin bad++; $display("FAIL busy_done t=%0d got %b want 10", t, {ifc.busy_o, ifc.done_o}); end
      eb = kind == 1 ? a : kind == 2 ? d : kind == 3 ? rv : 8'hFF;
      total++;
      if (bus_io !== eb) begin bad++; $display("FAIL bus t=%0d got %h want %h", t, bus_io, eb); end
    end
    @(negedge clk);
    m_valid = 1'b1; m_addr = a;
    if (rw) m_rdata = rv;
    total++;
    if ({ifc.busy_o, ifc.done_o, ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o} !== 6'b011111) begin
      bad++; $display("FAIL done_cycle got %b want 011111", {ifc.busy_o, ifc.done_o, ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o});
    end
    total++;
    if (ifc.rdata_o !== m_rdata) begin bad++; $display("FAIL rdata got %h want %h", ifc.rdata_o, m_rdata); end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      ifc.start_i = 1'($urandom); ifc.rw_i = 1'($urandom); ifc.addr_i = 8'($urandom); ifc.wdata_i = 8'($urandom);
      @(negedge clk);
      total++;
      if ({ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o, ifc.busy_o, ifc.done_o} !== 6'b111100 || ifc.rdata_o !== 8'h00 || bus_io !== 8'hFF) begin
        bad++; $display("FAIL reset got pins %b busy %b done %b rdata %h bus %h want 1111 0 0 00 FF",
          {ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o}, ifc.busy_o, ifc.done_o, ifc.rdata_o, bus_io);
      end
    end
    ifc.start_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_write;
    run_txn(1'b0, 8'h21, 8'h45, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic test_read;
    run_txn(1'b1, 8'h22, 8'h00, 8'h59, 1'b0, 1'b0);
  endtask
  task automatic test_random;
    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom), 8'($urandom_range(0, 8'hEF)), 8'($urandom_range(0, 8'hFE)), 8'($urandom), 1'b0, 1'b0);
  endtask
  task automatic test_ignore_start;
    run_txn(1'b0, 8'h33, 8'h5A, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ifc.busy_o, ifc.done_o, ifc.cs_o} !== 3'b001) begin
        bad++; $display("FAIL ignore_idle got busy/done/cs %b want 001", {ifc.busy_o, ifc.done_o, ifc.cs_o});
      end
    end
  endtask
  task automatic test_back_to_back;
    run_txn(1'b1, 8'h40, 8'h00, 8'hA7, 1'b1, 1'b0);
    run_txn(1'b0, 8'h41, 8'h3C, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic test_reset_abort;
    bit sk;
    sk = SKIP && m_valid && m_addr == 8'h52;
    ifc.rw_i = 1'b0; ifc.addr_i = 8'h52; ifc.wdata_i = 8'hC3; ifc.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start_i = 1'b0;
    repeat ((sk ? 0 : A + G) + S + 3) @(negedge clk);
    total++;
    if (ifc.wr_o !== 1'b0) begin bad++; $display("FAIL abort_pre wr got %b want 0", ifc.wr_o); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o, ifc.busy_o, ifc.done_o} !== 6'b111100 || bus_io !== 8'hFF) begin
      bad++; $display("FAIL abort got pins %b busy %b done %b bus %h want 1111 0 0 FF",
        {ifc.ad_o, ifc.cs_o, ifc.rd_o, ifc.wr_o}, ifc.busy_o, ifc.done_o, bus_io);
    end
    @(negedge clk);
    reset = 1'b1;
    m_valid = 1'b0;
    m_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ifc.done_o !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", ifc.done_o); end
    end
    run_txn(1'b0, 8'h52, 8'hC3, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic test_addr_skip;
    run_txn(1'b0, 8'hF0, 8'h11, 8'h00, 1'b0, 1'b0);
    run_txn(1'b0, 8'hF0, 8'h22, 8'h00, 1'b0, 1'b0);
    run_txn(1'b1, 8'hF0, 8'h00, 8'h6D, 1'b0, 1'b0);
    run_txn(1'b0, 8'hF1, 8'h33, 8'h00, 1'b0, 1'b0);
  endtask
  initial begin
    ifc.start_i = 1'b0; ifc.rw_i = 1'b0; ifc.addr_i = 8'h00; ifc.wdata_i = 8'h00;
    @(negedge clk);
    fork
      begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_addr_skip();
      end
      begin
        repeat (5000) @(negedge clk);
        bad++;
        $display("FAIL timeout got 5000 cycles want completion");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle engine between the RTC control FSM and the RTC chip pins. Each request from the controller becomes one complete multiplexed address/data transaction (address phase, then data phase) on the shared 8-bit bus, with programmable setup, strobe, hold and gap times. The block drives A/D select, chip select, RD and WR and owns the bidirectional AD pins. It returns read data and a completion pulse to the controller.

## Interface
Parameters:
- T_SETUP, 2: clocks address/data is valid with CS low before a strobe falls.
- T_PULSE, 10: clocks the RD/WR strobe is held low.
- T_HOLD, 2: clocks address/data stays valid after a strobe rises.
- T_GAP, 5: clocks with CS high between the address and data phases.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; forces idle immediately.
- start_i  in  1  request strobe; sampled only in IDLE.
- rw_i  in  1  1 = read, 0 = write.
- addr_i  in  8  RTC register address.
- wdata_i  in  8  write data.
- rdata_o  out  8  read data; holds until the next read completes.
- busy_o  out  1  transaction in progress.
- done_o  out  1  one-clock completion pulse.
- ad_o  out  1  A/D select: 0 = address phase, 1 = data phase or idle.
- cs_o  out  1  chip select, active-low.
- rd_o  out  1  read strobe, active-low.
- wr_o  out  1  write strobe, active-low.
- bus_io  inout  8  multiplexed AD pins; high-Z when not driven.

## Operation
- All pin outputs and the bus output enable are registered; there are no combinational paths from inputs to pins.
- States are IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD.
- A shared 8-bit down-counter sets each state's duration. Every parameter must be in the range 1..255.
- IDLE: cs=rd=wr=ad=1, bus high-Z. When start_i=1, latch rw_i/addr_i/wdata_i and go to A_SETUP. Later input changes are ignored.
- A_SETUP (T_SETUP): ad=0, cs=0, drive latched address.
- A_STROBE (T_PULSE): as A_SETUP, plus wr=0. The address is always written with WR, including for reads.
- A_HOLD (T_HOLD): wr=1; address still driven, cs=0.
- GAP (T_GAP): cs=1, ad=1, bus high-Z.
- D_SETUP (T_SETUP): cs=0, ad=1. On a write, drive wdata. On a read, the bus stays high-Z.
- D_STROBE (T_PULSE): wr=0 for a write, rd=0 for a read. On a read, rdata_o captures bus_io on the last D_STROBE clock.
- D_HOLD (T_HOLD): strobe high, cs=0; a write keeps driving data. Then go to IDLE.
- The block never drives the bus while rd_o=0.
- start_i while busy is ignored; it is not queued.

## Timing
- Reset values: ad_o=cs_o=rd_o=wr_o=1, bus high-Z, busy_o=0, done_o=0, rdata_o=0x00.
- If start is sampled at edge k, A_SETUP outputs appear after edge k.
- Full transaction latency is L = 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP clocks, which is 33 at the defaults.
- done_o=1 for exactly one clock after edge k+L. In that cycle the state is already IDLE and busy_o=0.
- busy_o=1 from edge k to edge k+L.
- A start_i sampled in the done_o cycle is accepted, giving back-to-back transactions separated only by the idle cycle.
- Reset asserted mid-transaction takes effect immediately: all outputs return to reset values and no done_o is generated.

## Configuration
- RTC_BUS_ADDR_SKIP_EN defined:
  - A valid flag and the last transaction's address are kept; reset clears the flag.
  - On accept, if the flag is set and addr_i equals the stored address, IDLE goes directly to D_SETUP.
  - Latency in that case is T_SETUP+T_PULSE+T_HOLD (14 at defaults).
  - The flag is set only by a completed transaction; a transaction aborted by reset does not set it.
- Undefined: every transaction runs the full address phase, and no address storage is synthesized.

## Test plan
- Reset held low with random inputs -> ad/cs/rd/wr=1, bus Z, busy=0, done=0, rdata=0x00.
- Write 0x45 to addr 0x21 -> address phase:
  - bus=0x21 with ad=0, cs=0; wr low exactly 10 clocks.
  - After the 5-clock gap, bus=0x45 with ad=1 and wr low 10 clocks.
  - rd stays 1; done pulses 33 clocks after start.
- Read addr 0x22, bus model drives 0x59 while rd=0 -> wr pulses only in the address phase; block never drives the bus in the data phase; rdata=0x59 in the done cycle.
- start_i pulsed at clock 10 of a transaction -> ignored, exactly one done. start_i held high through the done cycle -> second transaction begins the next clock.
- Reset asserted during D_STROBE of a write -> wr=1 and bus Z immediately, no done. The next transaction completes normally in 33 clocks.
- RTC_BUS_ADDR_SKIP_EN defined, two writes to 0xF0 -> first takes 33 clocks, second 14 with ad never 0. A following write to 0xF1 takes 33.
